aes128_multikey_engine: RTL and testbench
=========================================

// Module: aes128_multikey_engine
// PURPOSE
// - Iterative AES-128 encryptor, one round per clock, with KEY_SLOTS stored keys selectable per block.
// - Plaintext enters on a valid/ready handshake; ciphertext leaves through an OUT_DEPTH-entry output FIFO with its own valid/ready handshake.
// - Successor to the single-key encryption top-level; sits between the input deserialiser and the output FIFO/serialiser.
// PARAMETERS
// - KEY_SLOTS  4   number of stored 128-bit keys (>=1); KW = max(1,$clog2(KEY_SLOTS))
// - OUT_DEPTH  4   output FIFO depth in blocks (>=1); CW = $clog2(OUT_DEPTH+1)
// - ROUNDS     10  rounds per block (1..10); 10 = FIPS-197, <10 = reduced-round debug only
// PORTS
// - clk          in   1    clock; all state updates on the rising edge
// - rst          in   1    reset, asynchronous, active-high
// - key_load     in   1    write key_in into slot key_wr_id this edge
// - key_wr_id    in   KW   key slot written by key_load
// - key_in       in   128  cipher key, byte 0 in bits [127:120]
// - in_valid     in   1    plaintext block offered
// - in_ready     out  1    engine accepts the block this edge
// - in_data      in   128  plaintext, byte 0 in bits [127:120]
// - in_key_id    in   KW   key slot used for this block
// - out_valid    out  1    FIFO non-empty; out_data valid
// - out_ready    in   1    consumer pops the head entry this edge
// - out_data     out  128  ciphertext at FIFO head
// - busy         out  1    a block is in the round pipeline
// - fifo_count   out  CW   FIFO occupancy, 0..OUT_DEPTH
// BEHAVIOUR
// - Reset: in_ready=0 during rst, then 1 in the first cycle after; out_valid=0, busy=0, fifo_count=0; out_data=0; key slots=0; FSM=IDLE.
// - FSM IDLE -> RUN on accept; RUN -> IDLE on the edge completing round ROUNDS.
// - Accept: in_valid & in_ready at edge N. in_ready = (state==IDLE) & (fifo_count < OUT_DEPTH), purely from registered state.
// - Edge N: state <= in_data ^ slot[in_key_id]; rkey <= slot[in_key_id]; rnd <= 1.
// - Each RUN edge: rkey <= KeyExpansion step(rkey, Rcon[rnd]).
// - Each RUN edge, rnd<ROUNDS: state <= MixColumns(ShiftRows(SubBytes(state))) ^ next rkey.
// - Each RUN edge, rnd==ROUNDS: MixColumns omitted; result written to FIFO tail.
// - Latency: ciphertext written at edge N+ROUNDS; out_valid=1 from that edge if FIFO was empty.
// - Throughput: next accept possible at edge N+ROUNDS+1 (one block per ROUNDS+1 cycles).
// - busy = (state==RUN).
// - Datapath uses the team's sb/sr/mc combinational units and keygen-style expansion.
// - Rcon = 01,02,04,08,10,20,40,80,1b,36 for rnd 1..10.
// - FIFO: push only on round completion; pop on out_valid & out_ready.
// - FIFO, push and pop in same edge: count unchanged, order preserved.
// - FIFO pointers wrap modulo OUT_DEPTH (non-power-of-2 depths legal).
// - Overflow cannot occur: accept requires count<OUT_DEPTH, so space is reserved at accept.
// - out_ready while empty is ignored; out_data holds last head value.
// - key_load is honoured in any state.
//   - Accept uses the slot value before the same-edge write.
//   - Rewriting the slot of an in-flight block does not affect that block (key copied into rkey at accept).
// - Key ID wrap: in_key_id/key_wr_id >= KEY_SLOTS when KEY_SLOTS is not a power of 2: key_load ignored; accept uses slot 0.
// - rst asserted mid-operation: in-flight block and FIFO contents discarded; key slots cleared; no partial output.
// CONFIGURATION
// - Macro AES_CBC_EN defined: per-slot 128-bit chain register, cleared to 0 by reset and by key_load to that slot.
//   - Accept XORs in_data with chain[in_key_id] before the initial AddRoundKey.
//   - Round completion writes the ciphertext into chain[slot of that block].
//   - First block after key_load = plain ECB (IV=0).
// - Macro undefined: pure ECB, no chain registers; ports identical in both builds.
// TESTING
// - Vector B: slot0=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 accepted at edge N
//   -> out_data=3925841d02dc09fbdc118597196a0b32, out_valid high from edge N+10.
// - Vector C.1: slot2=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff, in_key_id=2
//   -> ct=69c4e0d86a7b0430d8cdb78070b4c55a.
// - Backpressure: out_ready=0, 5 blocks offered, OUT_DEPTH=4
//   -> 4 accepted, fifo_count=4, in_ready=0.
//   Then out_ready=1 -> FIFO drains in order, 5th block accepted on the edge after the first pop.
// - key_load to slot0 on the accept edge and again mid-block
//   -> block ciphertext uses old key; next block uses new key.
// - rst pulsed at round 5 -> busy=0, out_valid=0, fifo_count=0 immediately; no ciphertext ever emitted for that block.
// - AES_CBC_EN, key C.1, two identical pts:
//   -> block1=69c4e0d86a7b0430d8cdb78070b4c55a, block2=AES(pt^block1).
//   Repeat with the macro undefined -> both equal 69c4e0d8...

Source files
------------

// File: rtl/aes128_multikey_engine.sv
// Iterative AES-128 encryptor (one round per clock) with KEY_SLOTS stored keys and an output FIFO.
// Optional macro AES_CBC_EN adds a per-slot CBC chain register; otherwise the engine is pure ECB.
module aes128_multikey_engine #(
  parameter int KEY_SLOTS = 4,
  parameter int OUT_DEPTH = 4,
  parameter int ROUNDS    = 10,
  localparam int KW = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1,
  localparam int CW = $clog2(OUT_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [KW-1:0] key_wr_id,
  input  logic [127:0]  key_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic [KW-1:0] in_key_id,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid in the same cycle.

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    int idx;
    idx = 255 - int'(x);
    return SBOX_TBL[idx*8 +: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[i*8 +: 8] = sbox(s[i*8 +: 8]);
    return o;
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Rolling key schedule: derives round key r from round key r-1.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Out-of-range ids (only possible for non power-of-2 KEY_SLOTS) fall back to slot 0.
  function automatic logic [KW-1:0] slot_of(input logic [KW-1:0] id);
    if (int'(id) >= KEY_SLOTS) return '0;
    return id;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == OUT_DEPTH - 1) return '0;
    return p + PW'(1);
  endfunction

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t          fsm;
  logic [127:0]  key_slot [KEY_SLOTS];
  logic [127:0]  st;
  logic [127:0]  rkey;
  logic [3:0]    rnd;

  logic [127:0]  fifo_mem [OUT_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [127:0]  head_hold;

  logic          accept;
  logic          push;
  logic          pop;
  logic          key_wr_ok;
  logic [KW-1:0] acc_slot;
  logic [127:0]  acc_key;
  logic [127:0]  acc_pt;
  logic [127:0]  next_rkey;
  logic [127:0]  sbsr;
  logic [127:0]  round_out;
  logic [127:0]  final_out;

`ifdef AES_CBC_EN
  logic [127:0]  chain [KEY_SLOTS];
  logic [KW-1:0] blk_slot;
`endif

  assign in_ready   = ~rst & (fsm == IDLE) & (count < CW'(OUT_DEPTH));
  assign busy       = (fsm == RUN);
  assign out_valid  = (count != '0);
  assign fifo_count = count;
  assign out_data   = out_valid ? fifo_mem[rd_ptr] : head_hold;

  always_comb begin
    accept    = in_valid & in_ready;
    push      = (fsm == RUN) && (rnd == 4'(ROUNDS));
    pop       = out_valid & out_ready;
    key_wr_ok = key_load && (int'(key_wr_id) < KEY_SLOTS);
    acc_slot  = slot_of(in_key_id);
    acc_key   = key_slot[acc_slot];
`ifdef AES_CBC_EN
    acc_pt    = in_data ^ chain[acc_slot];
`else
    acc_pt    = in_data;
`endif
    next_rkey = key_step(rkey, rcon(rnd));
    sbsr      = shift_rows(sub_bytes(st));
    round_out = mix_columns(sbsr) ^ next_rkey;
    final_out = sbsr ^ next_rkey;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm  <= IDLE;
      st   <= '0;
      rkey <= '0;
      rnd  <= '0;
      for (int i = 0; i < KEY_SLOTS; i++) key_slot[i] <= '0;
    end else begin
      if (key_wr_ok) key_slot[key_wr_id] <= key_in;
      case (fsm)
        IDLE: begin
          if (accept) begin
            st   <= acc_pt ^ acc_key;
            rkey <= acc_key;
            rnd  <= 4'd1;
            fsm  <= RUN;
          end
        end
        RUN: begin
          rkey <= next_rkey;
          if (rnd == 4'(ROUNDS)) begin
            fsm <= IDLE;
          end else begin
            st  <= round_out;
            rnd <= rnd + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Space for a block is reserved at accept, so push never meets a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_hold <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      head_hold <= out_data;
      if (push) begin
        fifo_mem[wr_ptr] <= final_out;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

`ifdef AES_CBC_EN
  // A key write to a slot wins over a same-edge chain update for that slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_slot <= '0;
      for (int i = 0; i < KEY_SLOTS; i++) chain[i] <= '0;
    end else begin
      if (accept) blk_slot <= acc_slot;
      if (push) chain[blk_slot] <= final_out;
      if (key_wr_ok) chain[key_wr_id] <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_aes128_multikey_engine.sv
// Self-checking bench for aes128_multikey_engine: FIPS-197 vectors, table of random vectors
// against an independent reference model, plus latency, backpressure, key-rewrite and reset sequences.
module tb_aes128_multikey_engine;

  localparam int KEY_SLOTS = 4;
  localparam int OUT_DEPTH = 4;
  localparam int ROUNDS    = 10;
  localparam int KW        = 2;
  localparam int CW        = 3;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_load;
  logic [KW-1:0] key_wr_id;
  logic [127:0]  key_in;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [KW-1:0] in_key_id;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          busy;
  logic [CW-1:0] fifo_count;

  aes128_multikey_engine #(.KEY_SLOTS(KEY_SLOTS), .OUT_DEPTH(OUT_DEPTH), .ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_wr_id(key_wr_id), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key_id(in_key_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   ref_sbox [256];
  logic [127:0] bk     [KEY_SLOTS];
  logic [127:0] bchain [KEY_SLOTS];
  int           acc_cyc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (GF arithmetic, full key schedule) ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      ref_sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [4*(ROUNDS+1)];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4*(ROUNDS+1); i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {ref_sbox[tmp[23:16]], ref_sbox[tmp[15:8]], ref_sbox[tmp[7:0]], ref_sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= ROUNDS; r++) begin
      for (int i = 0; i < 16; i++) t[i] = ref_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c+j] = t[4*((c+j)%4)+j];
      if (r != ROUNDS) begin
        for (int c = 0; c < 4; c++) begin
          t[0] = gf_mul(8'h02, s[4*c]) ^ gf_mul(8'h03, s[4*c+1]) ^ s[4*c+2] ^ s[4*c+3];
          t[1] = s[4*c] ^ gf_mul(8'h02, s[4*c+1]) ^ gf_mul(8'h03, s[4*c+2]) ^ s[4*c+3];
          t[2] = s[4*c] ^ s[4*c+1] ^ gf_mul(8'h02, s[4*c+2]) ^ gf_mul(8'h03, s[4*c+3]);
          t[3] = gf_mul(8'h03, s[4*c]) ^ s[4*c+1] ^ s[4*c+2] ^ gf_mul(8'h02, s[4*c+3]);
          for (int j = 0; j < 4; j++) s[4*c+j] = t[j];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] exp_for(input int id, input logic [127:0] pt);
`ifdef AES_CBC_EN
    return ref_aes(bk[id], pt ^ bchain[id]);
`else
    return ref_aes(bk[id], pt);
`endif
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h required no output", out_data);
      end else begin
        check("ciphertext", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int id, input logic [127:0] k);
    key_load  = 1'b1;
    key_wr_id = KW'(id);
    key_in    = k;
    tick();
    key_load  = 1'b0;
    bk[id]     = k;
    bchain[id] = '0;
  endtask

  task automatic send_block(input int id, input logic [127:0] pt, input logic [127:0] exp);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    in_key_id = KW'(id);
    in_data   = pt;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", waited);
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    exp_q.push_back(exp);
    bchain[id] = exp;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && waited < 400) begin
      waited++;
      tick();
    end
    if (waited >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d entries outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- test ----------------
  typedef struct {
    int           slot;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int           lat;
    int           a0;
    logic [127:0] pt5;
    logic [127:0] exp5;
    logic [127:0] blk1;
    logic [127:0] blk2;
    logic [127:0] kx;

    rst = 1'b1; key_load = 1'b0; key_wr_id = '0; key_in = '0;
    in_valid = 1'b0; in_data = '0; in_key_id = '0; out_ready = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) begin bk[i] = '0; bchain[i] = '0; end
    init_sbox();

    tbl[0] = '{0, KEY_B, PT_B, CT_B};
    tbl[1] = '{2, KEY_C, PT_C, CT_C};
    for (int i = 2; i < 8; i++) begin
      tbl[i].slot = $urandom_range(0, KEY_SLOTS-1);
      tbl[i].key  = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].pt   = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].ct   = ref_aes(tbl[i].key, tbl[i].pt);
    end

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_out_data", out_data, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven vectors, fresh key per record
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_drain();
      load_key(tbl[i].slot, tbl[i].key);
      send_block(tbl[i].slot, tbl[i].pt, tbl[i].ct);
    end
    wait_drain();

    // Latency and busy with vector B
    load_key(0, KEY_B);
    send_block(0, PT_B, CT_B);
    lat = 0;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, ROUNDS);
    check("busy_at_output", busy, 0);
    wait_drain();

    // Back-to-back throughput: accepts ROUNDS+1 cycles apart
    send_block(0, PT_B, exp_for(0, PT_B));
    a0 = acc_cyc;
    send_block(0, PT_B, exp_for(0, PT_B));
    check("accept_spacing", acc_cyc - a0, ROUNDS + 1);
    wait_drain();

    // Backpressure: 4 blocks fill the FIFO, the 5th waits for the first pop
    load_key(2, KEY_C);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pt5 = {$urandom, $urandom, $urandom, $urandom};
      send_block(2, pt5, exp_for(2, pt5));
    end
    lat = 0;
    while (fifo_count != CW'(OUT_DEPTH) && lat < 50) begin
      tick();
      lat++;
    end
    check("bp_fifo_full", fifo_count, OUT_DEPTH);
    check("bp_in_ready_low", in_ready, 0);
    pt5  = {$urandom, $urandom, $urandom, $urandom};
    exp5 = exp_for(2, pt5);
    in_valid = 1'b1; in_key_id = KW'(2); in_data = pt5;
    repeat (3) tick();
    check("bp_no_accept", busy, 0);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_ready_after_pop", in_ready, 1);
    check("bp_count_after_pop", fifo_count, OUT_DEPTH - 1);
    exp_q.push_back(exp5);
    bchain[2] = exp5;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_fifth_accepted", busy, 1);
    wait_drain();

    // key_load on the accept edge and mid-block: block keeps the old key
    load_key(0, KEY_B);
    kx = {$urandom, $urandom, $urandom, $urandom};
    key_load = 1'b1; key_wr_id = '0; key_in = kx;
    in_valid = 1'b1; in_key_id = '0; in_data = PT_B;
    @(negedge clk);
    check("kl_ready", in_ready, 1);
    exp_q.push_back(CT_B);
    tick();
    key_load = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    load_key(0, KEY_C);
    bchain[0] = CT_B;
    send_block(0, PT_C, exp_for(0, PT_C));
    wait_drain();

    // Two identical plaintexts under key C.1
    load_key(2, KEY_C);
    blk1 = CT_C;
`ifdef AES_CBC_EN
    blk2 = ref_aes(KEY_C, PT_C ^ CT_C);
`else
    blk2 = CT_C;
`endif
    send_block(2, PT_C, blk1);
    send_block(2, PT_C, blk2);
    wait_drain();

    // Reset at round 5: nothing emitted, slots cleared
    load_key(1, {$urandom, $urandom, $urandom, $urandom});
    send_block(1, PT_B, exp_for(1, PT_B));
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_fifo_count", fifo_count, 0);
    void'(exp_q.pop_back());
    for (int i = 0; i < KEY_SLOTS; i++) begin bk[i] = '0; bchain[i] = '0; end
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_output", fifo_count, 0);
    send_block(1, PT_B, exp_for(1, PT_B));
    wait_drain();

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
